alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits (legal 8..64, power of two).
REQ-002 SHALL have derived localparam: SHW, $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port: rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port: in_valid  input  1  operation request.
REQ-006 SHALL have port: in_ready  output  1  unit can accept; high only in IDLE with rst_n high.
REQ-007 SHALL have port: op  input  4  operation code (alu_pkg).
REQ-008 SHALL have ports: src_a, src_b  input  WIDTH  operands.
REQ-009 SHALL have port: out_valid  output  1  result available.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port: result  output  WIDTH  registered result.
REQ-012 SHALL have port: zero  output  1  registered (result == 0), for branch decisions.
REQ-013 SHALL have port: busy  output  1  high in CALC state.

Function
REQ-014 SHALL implement single-cycle ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA (shift by src_b[SHW-1:0]), SLT (signed), SLTU (unsigned); result is 1 or 0 for SLT/SLTU.
REQ-015 SHALL implement iterative ops: MUL (low WIDTH bits of product), DIV, DIVU, REM, REMU.
REQ-016 SHALL decode unlisted op codes as ADD.
REQ-017 SHALL use FSM states IDLE, CALC, DONE; request accepted on the edge where in_valid && in_ready.
REQ-018 SHALL, for single-cycle ops, go IDLE->DONE; out_valid is high one cycle after acceptance.
REQ-019 SHALL, for iterative ops, go IDLE->CALC; run exactly WIDTH iterations (down-counter), then CALC->DONE; out_valid is high WIDTH+1 cycles after acceptance.
REQ-020 SHALL run MUL as shift-add and division as restoring shift-subtract, one bit per cycle, on magnitudes; signed ops negate the quotient when the operand signs differ and give the remainder the sign of the dividend.
REQ-021 SHALL, on divide by zero, bypass CALC (latency 1): DIV/DIVU quotient all ones, REM/REMU remainder = src_a.
REQ-022 SHALL, on signed overflow (src_a = most-negative, src_b = -1), bypass CALC (latency 1): DIV -> most-negative, REM -> 0.
REQ-023 SHALL latch op and operands at acceptance; input changes during CALC/DONE have no effect.
REQ-024 SHALL hold result, zero, out_valid stable in DONE until out_ready; DONE->IDLE on the edge where out_ready is high.
REQ-025 SHALL NOT accept a new request in the DONE->IDLE cycle (in_ready low in DONE); back-to-back throughput is one op per 2 cycles minimum.
REQ-026 SHALL update zero in the same cycle as result.

Reset
REQ-027 SHALL, while rst_n is low at a clock edge, force state IDLE, out_valid 0, result 0, zero 0, busy 0, counter 0; in_ready 0 while rst_n low.
REQ-028 SHALL abort any CALC or DONE operation on reset; the aborted result is never presented.

Structure
REQ-029 SHALL take op codes (4-bit) and the state enum from package alu_pkg, shared with the decoder.
REQ-030 SHALL place the iterative multiply/divide datapath (accumulator, remainder, counter, sign fix-up) in one sub-module alu_muldiv_seq; single-cycle ops and FSM stay in alu_mc.

Verification
REQ-031 SHALL check ADD 0x7FFFFFFF + 1 -> result 0x80000000, zero 0, out_valid 1 cycle after accept; SUB 5-5 -> 0, zero 1.
REQ-032 SHALL check SRA 0x80000000 by 31 -> 0xFFFFFFFF; SRL same -> 0x00000001; SLT -1,1 -> 1; SLTU -1,1 -> 0.
REQ-033 SHALL check DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF, MUL 0xFFFF*0x10001 -> 0xFFFFFFFF, each out_valid exactly 33 cycles after accept, busy high 32 cycles.
REQ-034 SHALL check DIVU 10/0 -> 0xFFFFFFFF, REMU 10/0 -> 10, DIV 0x80000000/-1 -> 0x80000000, all with latency 1.
REQ-035 SHALL check backpressure: out_ready low 5 cycles in DONE -> result/zero stable, in_ready low, in_valid ignored; then out_ready high -> IDLE next cycle.
REQ-036 SHALL check rst_n low for one edge mid-CALC -> out_valid never asserts for that op, next op (ADD 2+3) returns 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM states and
// small op-classification helpers used by the decoder and the datapath.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10,
        OP_DIV  = 4'd11,
        OP_DIVU = 4'd12,
        OP_REM  = 4'd13,
        OP_REMU = 4'd14
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    // Ops that normally run on the bit-serial multiply/divide datapath.
    function automatic logic op_is_iter(input logic [3:0] op);
        logic r;
        case (op)
            OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU: r = 1'b1;
            default:                                  r = 1'b0;
        endcase
        return r;
    endfunction

    // Any of the four divide-family ops.
    function automatic logic op_is_div(input logic [3:0] op);
        logic r;
        case (op)
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: r = 1'b1;
            default:                          r = 1'b0;
        endcase
        return r;
    endfunction

    // Divide-family ops that treat operands as two's complement.
    function automatic logic op_is_signed_div(input logic [3:0] op);
        logic r;
        case (op)
            OP_DIV, OP_REM: r = 1'b1;
            default:        r = 1'b0;
        endcase
        return r;
    endfunction

    // Divide-family ops that return the remainder rather than the quotient.
    function automatic logic op_is_rem(input logic [3:0] op);
        logic r;
        case (op)
            OP_REM, OP_REMU: r = 1'b1;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Bit-serial multiply / restoring divide engine. Works on magnitudes,
// one bit per step, and applies the sign fix-up on the final step.
// res_o is the fixed-up result of the step that is about to happen, so the
// owner can register it on the same edge that last_o is high.
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             step_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] res_o
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = {{SHW{1'b0}}, 1'b1};

    logic             is_mul_q;
    logic             is_rem_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic [WIDTH-1:0] acc_q;   // product accumulator / partial remainder
    logic [WIDTH-1:0] opa_q;   // multiplicand / dividend shifting into quotient
    logic [WIDTH-1:0] opb_q;   // multiplier / divisor
    logic [SHW:0]     cnt_q;

    logic             a_neg_s;
    logic             b_neg_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [WIDTH-1:0] shl_s;
    logic             ge_s;
    logic [WIDTH-1:0] acc_n_s;
    logic [WIDTH-1:0] opa_n_s;
    logic [WIDTH-1:0] opb_n_s;

    // Operand magnitudes taken at start for the signed divide ops.
    always_comb begin
        a_neg_s = op_is_signed_div(op_i) & a_i[WIDTH-1];
        b_neg_s = op_is_signed_div(op_i) & b_i[WIDTH-1];
        a_mag_s = a_neg_s ? ({WIDTH{1'b0}} - a_i) : a_i;
        b_mag_s = b_neg_s ? ({WIDTH{1'b0}} - b_i) : b_i;
    end

    // One iteration: shift-add for multiply, shift-subtract for divide.
    always_comb begin
        shl_s = {acc_q[WIDTH-2:0], opa_q[WIDTH-1]};
        // The shifted remainder has a hidden bit acc_q[WIDTH-1]; when set it
        // is always at least the divisor, and the modular subtraction below
        // still yields the correct (smaller than divisor) remainder.
        ge_s  = acc_q[WIDTH-1] | (shl_s >= opb_q);
        if (is_mul_q) begin
            acc_n_s = acc_q + (opb_q[0] ? opa_q : {WIDTH{1'b0}});
            opa_n_s = {opa_q[WIDTH-2:0], 1'b0};
            opb_n_s = {1'b0, opb_q[WIDTH-1:1]};
        end else begin
            acc_n_s = ge_s ? (shl_s - opb_q) : shl_s;
            opa_n_s = {opa_q[WIDTH-2:0], ge_s};
            opb_n_s = opb_q;
        end
    end

    // Final result with the sign fix-up for signed divide and remainder.
    always_comb begin
        last_o = (cnt_q == CNT_ONE);
        if (is_mul_q) begin
            res_o = acc_n_s;
        end else if (is_rem_q) begin
            res_o = neg_rem_q ? ({WIDTH{1'b0}} - acc_n_s) : acc_n_s;
        end else begin
            res_o = neg_quo_q ? ({WIDTH{1'b0}} - opa_n_s) : opa_n_s;
        end
    end

    // Datapath registers: load on start, advance one bit per step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            is_mul_q  <= 1'b0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= {WIDTH{1'b0}};
            opa_q     <= {WIDTH{1'b0}};
            opb_q     <= {WIDTH{1'b0}};
            cnt_q     <= {(SHW+1){1'b0}};
        end else if (start_i) begin
            is_mul_q  <= (op_i == OP_MUL);
            is_rem_q  <= op_is_rem(op_i);
            neg_quo_q <= a_neg_s ^ b_neg_s;
            neg_rem_q <= a_neg_s;
            acc_q     <= {WIDTH{1'b0}};
            opa_q     <= (op_i == OP_MUL) ? a_i : a_mag_s;
            opb_q     <= (op_i == OP_MUL) ? b_i : b_mag_s;
            cnt_q     <= CNT_INIT;
        end else if (step_i && (cnt_q != {(SHW+1){1'b0}})) begin
            acc_q     <= acc_n_s;
            opa_q     <= opa_n_s;
            opb_q     <= opb_n_s;
            cnt_q     <= cnt_q - CNT_ONE;
        end else begin
            cnt_q     <= cnt_q;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift/compare ops, iterative
// multiply/divide via alu_muldiv_seq, valid/ready handshake on both sides.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    alu_state_e       state_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [SHW-1:0]   shamt_s;
    logic signed [WIDTH-1:0] sra_s;
    logic             div0_s;
    logic             ovf_s;
    logic             bypass_s;
    logic [WIDTH-1:0] fast_res_s;
    logic             start_s;
    logic             step_s;
    logic             md_last_s;
    logic [WIDTH-1:0] md_res_s;

    assign in_ready  = rst_n & (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign busy      = busy_q;

    // Divide corner cases that are answered immediately instead of iterating.
    always_comb begin
        div0_s   = (src_b == {WIDTH{1'b0}});
        ovf_s    = op_is_signed_div(op) & (src_a == MOST_NEG) & (src_b == ALL_ONES);
        bypass_s = op_is_div(op) & (div0_s | ovf_s);
        start_s  = (state_q == IDLE) & in_valid & op_is_iter(op) & ~bypass_s;
        step_s   = (state_q == CALC);
    end

    // Single-cycle result, including the divide bypass values.
    always_comb begin
        shamt_s = src_b[SHW-1:0];
        sra_s   = $signed(src_a) >>> shamt_s;
        case (op)
            OP_SUB:  fast_res_s = src_a - src_b;
            OP_AND:  fast_res_s = src_a & src_b;
            OP_OR:   fast_res_s = src_a | src_b;
            OP_XOR:  fast_res_s = src_a ^ src_b;
            OP_SLL:  fast_res_s = src_a << shamt_s;
            OP_SRL:  fast_res_s = src_a >> shamt_s;
            OP_SRA:  fast_res_s = sra_s;
            OP_SLT:  fast_res_s = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: fast_res_s = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            default: fast_res_s = src_a + src_b;
        endcase
        if (bypass_s) begin
            if (op_is_rem(op)) begin
                fast_res_s = div0_s ? src_a : {WIDTH{1'b0}};
            end else begin
                fast_res_s = div0_s ? ALL_ONES : MOST_NEG;
            end
        end else begin
            fast_res_s = fast_res_s;
        end
    end

    alu_muldiv_seq #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_s),
        .step_i  (step_s),
        .op_i    (op),
        .a_i     (src_a),
        .b_i     (src_b),
        .last_o  (md_last_s),
        .res_o   (md_res_s)
    );

    // Control FSM with registered result, zero, out_valid and busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            result_q    <= {WIDTH{1'b0}};
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (start_s) begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q     <= DONE;
                            result_q    <= fast_res_s;
                            zero_q      <= (fast_res_s == {WIDTH{1'b0}});
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (md_last_s) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        result_q    <= md_res_s;
                        zero_q      <= (md_res_s == {WIDTH{1'b0}});
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases, backpressure,
// reset during an iterative op, and random ops against an arithmetic model.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 32;
    localparam logic [W-1:0] MINV = 32'h8000_0000;
    localparam logic [W-1:0] ONES = 32'hFFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] src_a = 32'd0;
    logic [W-1:0] src_b = 32'd0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result from the arithmetic meaning of each op.
    function automatic logic [W-1:0] model_res(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int sa;
        int sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == MINV) && (b == ONES);
        case (o)
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return W'(sa >>> b[4:0]);
            OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_MUL:  return a * b;
            OP_DIVU: return (b == 32'd0) ? ONES : a / b;
            OP_REMU: return (b == 32'd0) ? a : a % b;
            OP_DIV:  return (b == 32'd0) ? ONES : (ovf ? MINV : W'(sa / sb));
            OP_REM:  return (b == 32'd0) ? a : (ovf ? 32'd0 : W'(sa % sb));
            default: return a + b;
        endcase
    endfunction

    // Reference accept-to-out_valid latency in cycles.
    function automatic int model_lat(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic ovf;
        ovf = (a == MINV) && (b == ONES);
        case (o)
            OP_MUL:          return W + 1;
            OP_DIVU, OP_REMU: return (b == 32'd0) ? 1 : W + 1;
            OP_DIV, OP_REM:  return (b == 32'd0 || ovf) ? 1 : W + 1;
            default:         return 1;
        endcase
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return ONES;
            2:       return MINV;
            3:       return W'($urandom_range(0, 15));
            4:       return ONES - W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check({tag, "_ready_timeout"}, 64'd0, 64'd1);
    endtask

    // Issue one op, scramble inputs while it runs, then check and drain it.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold);
        logic [W-1:0] exp;
        int exp_lat;
        int lat;
        int bcnt;
        exp     = model_res(o, a, b);
        exp_lat = model_lat(o, a, b);
        wait_ready(tag);
        op = o; src_a = a; src_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat  = 1;
        bcnt = 0;
        while (!out_valid && lat < 200) begin
            bcnt += int'(busy);
            op = 4'($urandom); src_a = $urandom; src_b = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_result"}, 64'(result), 64'(exp));
        check({tag, "_zero"}, 64'(zero), 64'(exp == 32'd0));
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat - 1));
        repeat (hold) begin
            @(posedge clk); #1;
        end
        check({tag, "_held"}, 64'(result), 64'(exp));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_drained"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int seen;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_zero", 64'(zero), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Directed corner cases
        run_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'd1, 0);
        run_op("sub_zero", OP_SUB, 32'd5, 32'd5, 1);
        run_op("sra31", OP_SRA, 32'h8000_0000, 32'd31, 0);
        run_op("srl31", OP_SRL, 32'h8000_0000, 32'd31, 0);
        run_op("slt", OP_SLT, ONES, 32'd1, 0);
        run_op("sltu", OP_SLTU, ONES, 32'd1, 0);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 2);
        run_op("mul", OP_MUL, 32'h0000_FFFF, 32'h0001_0001, 0);
        run_op("divu_by0", OP_DIVU, 32'd10, 32'd0, 0);
        run_op("remu_by0", OP_REMU, 32'd10, 32'd0, 0);
        run_op("div_ovf", OP_DIV, MINV, ONES, 0);
        run_op("rem_ovf", OP_REM, MINV, ONES, 0);
        run_op("op15_add", 4'd15, 32'd40, 32'd2, 0);

        // Backpressure: held in DONE with in_valid pulsing
        wait_ready("bp");
        op = OP_ADD; src_a = 32'd3; src_b = 32'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        check("bp_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; op = OP_SUB; src_a = 32'd9; src_b = 32'd4;
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_result", 64'(result), 64'd7);
            check("bp_zero", 64'(zero), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next_valid", 64'(out_valid), 64'd1);
        check("bp_next_result", 64'(result), 64'd5);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset pulse during CALC aborts the op
        wait_ready("rstcalc");
        op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("rstcalc_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rstcalc_in_ready_low", 64'(in_ready), 64'd0);
        check("rstcalc_busy", 64'(busy), 64'd0);
        check("rstcalc_result", 64'(result), 64'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("rstcalc_no_valid", 64'(seen), 64'd0);
        run_op("rstcalc_add", OP_ADD, 32'd2, 32'd3, 0);

        // Random ops
        for (int i = 0; i < 120; i++) begin
            run_op("rand", 4'($urandom_range(0, 15)), rnd_operand(), rnd_operand(),
                   int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
